aes_block_stager: RTL and testbench
===================================

AES_BLOCK_STAGER -- requirements
Module: aes_block_stager

Interface
REQ-001 Parameter DATA_W, default 32, is the register bus data width; DATA_W SHALL be at least 16.
REQ-002 Parameter KEY_W, default 128, is the key width; KEY_W SHALL be a multiple of DATA_W.
REQ-003 Parameter BLK_W, default 128, is the data block width; BLK_W SHALL be a multiple of DATA_W.
REQ-004 Parameter FIFO_ADDR, default 32'h0000_0510, is the data push/pop address.
REQ-005 Parameter STATUS_ADDR, default 32'h0000_0514, is the status/control address.
REQ-006 Parameter TIMEOUT_CYC, default 1024, is the core watchdog limit in cycles.
REQ-007 Derived N_IN=(KEY_W+BLK_W)/DATA_W and N_OUT=BLK_W/DATA_W SHALL each be between 1 and 15.
REQ-008 Clocking: one clock; reset is asynchronous and active-low (clk_main_a0, rst_main_n_sync).
REQ-009 clk_main_a0  in  1  sole clock, all logic on rising edge.
REQ-010 rst_main_n_sync  in  1  asynchronous active-low reset.
REQ-011 wr_addr  in  32  write address; wready  in  1  one-cycle write strobe; wdata  in  DATA_W  write data.
REQ-012 arvalid_q  in  1  read request; araddr_q  in  32  read address; rready  in  1  read data accept.
REQ-013 rvalid  out  1; rdata  out  DATA_W; rresp  out  2  read response.
REQ-014 core_start  out  1  one-cycle start pulse; core_key  out  KEY_W; core_din  out  BLK_W.
REQ-015 core_done  in  1  result strobe; core_dout  in  BLK_W  result, valid only while core_done=1.
REQ-016 irq_done  out  1  result-ready flag; ack  in  1  software acknowledge pulse.

Function
REQ-017 FSM states and status codes: IDLE=0, START=1, WAIT_CORE=2, DONE_FLAG=3, DRAIN=4.
REQ-018 IDLE: each wready with wr_addr==FIFO_ADDR stores wdata as word in_cnt of frame {core_key,core_din}, word 0 in the MSBs, then increments in_cnt.
REQ-019 When the write makes in_cnt equal N_IN, the FSM SHALL go to START on the next edge.
REQ-020 START: core_start=1 for exactly one cycle, clear in_cnt and the watchdog counter, then go to WAIT_CORE.
REQ-021 core_key/core_din SHALL hold stable from START until the FSM next returns to IDLE.
REQ-022 WAIT_CORE: on core_done, capture core_dout into the output buffer and go to DONE_FLAG.
REQ-023 WAIT_CORE: otherwise increment the watchdog; on reaching TIMEOUT_CYC, set sticky timeout and go to IDLE.
REQ-024 core_done on the terminal watchdog cycle SHALL win: result captured, no timeout.
REQ-025 DONE_FLAG: irq_done=1; an ack pulse moves the FSM to DRAIN; irq_done SHALL stay 1 through DRAIN.
REQ-026 A FIFO_ADDR write outside IDLE SHALL be dropped and set sticky overflow.
REQ-027 Read handshake: arvalid_q is accepted only while rvalid=0; the response appears the next cycle.
REQ-028 rvalid/rdata/rresp SHALL hold until rready=1; rvalid drops on the following edge.
REQ-029 Read of FIFO_ADDR in DRAIN: rdata = output word out_cnt (word 0 = MSBs), rresp=2'b00, out_cnt increments.
REQ-030 When the pop makes out_cnt equal N_OUT: clear out_cnt and irq_done, return to IDLE.
REQ-031 Read of FIFO_ADDR outside DRAIN: rdata=16'hdead zero-extended into the MS bits pattern 32'hdead_0000 truncated to DATA_W, rresp=2'b10, no state change.
REQ-032 STATUS_ADDR read layout: bit0 irq_done, bit1 overflow, bit2 timeout, [6:4] state code, [11:8] in_cnt, [15:12] out_cnt, others 0; rresp=2'b00.
REQ-033 Read of any other address: rdata=32'haaaa_aaaa truncated to DATA_W, rresp=2'b00.
REQ-034 Write to STATUS_ADDR with wdata[0]=1 SHALL abort from any state: FSM to IDLE, clear counters, irq_done and sticky flags on the next edge.
REQ-035 An abort in the same cycle as any other event SHALL take priority.
REQ-036 A write and a read in the same cycle SHALL both be processed independently.

Reset
REQ-037 On rst_main_n_sync=0, asynchronously: FSM=IDLE; in_cnt, out_cnt, watchdog=0; rvalid=0, rdata=0, rresp=0, core_start=0, irq_done=0; overflow and timeout=0.
REQ-038 Reset asserted mid-operation SHALL discard any partial frame, result and pending read response.

Verification
REQ-039 Eight writes 0x0..0x7 to 0x510 -> one core_start pulse; core_key=0x00000000_00000001_00000002_00000003; core_din=0x00000004_..._00000007.
REQ-040 core_done with core_dout=0x11111111_22222222_33333333_44444444, then ack, then four reads of 0x510 -> data 0x11111111, 0x22222222, 0x33333333, 0x44444444; irq_done=0 after the fourth read.
REQ-041 Read 0x510 in IDLE -> rdata 0xdead0000, rresp 2'b10; a 9th write during WAIT_CORE -> status bit1=1.
REQ-042 No core_done for 1024 cycles -> status reads 0x00000004 (timeout set, IDLE).
REQ-043 rready held 0 for 5 cycles -> rvalid and rdata stable for all 5 cycles.
REQ-044 Write 0x1 to 0x514 in DONE_FLAG -> status 0x00000000; reset pulse in WAIT_CORE -> all outputs 0.

Source files
------------

// File: rtl/aes_block_stager.sv
// Register-bus staging buffer for a block-cipher core: collects key+block words,
// launches the core with a watchdog, and hands the result back word by word.
`timescale 1ns/1ps
module aes_block_stager #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned KEY_W       = 128,
    parameter int unsigned BLK_W       = 128,
    parameter logic [31:0] FIFO_ADDR   = 32'h0000_0510,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0514,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n_sync,
    input  logic [31:0]       wr_addr,
    input  logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              arvalid_q,
    input  logic [31:0]       araddr_q,
    input  logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              core_start,
    output logic [KEY_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_din,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  core_dout,
    output logic              irq_done,
    input  logic              ack
);

    localparam int unsigned       FRAME_W   = KEY_W + BLK_W;
    localparam int unsigned       N_IN      = FRAME_W / DATA_W;
    localparam int unsigned       N_OUT     = BLK_W / DATA_W;
    localparam int unsigned       WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]        IN_LAST   = 4'(N_IN - 1);
    localparam logic [3:0]        OUT_LAST  = 4'(N_OUT - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(32'hdead_0000);
    localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'haaaa_aaaa);
    localparam logic [1:0]        RESP_OK   = 2'b00;
    localparam logic [1:0]        RESP_ERR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_CORE = 3'd2,
        ST_DONE_FLAG = 3'd3,
        ST_DRAIN     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          in_cnt_q, in_cnt_d;
    logic [3:0]          out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [BLK_W-1:0]    obuf_q, obuf_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;
    logic                core_start_q, core_start_d;
    logic                irq_q, irq_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [31:0]         status_s;
    logic                fifo_wr_s, abort_s, rd_fire_s, pop_s;

    assign fifo_wr_s = wready && (wr_addr == FIFO_ADDR);
    assign abort_s   = wready && (wr_addr == STATUS_ADDR) && wdata[0];
    assign rd_fire_s = arvalid_q && !rvalid_q;
    assign pop_s     = rd_fire_s && (araddr_q == FIFO_ADDR) && (state_q == ST_DRAIN);

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign core_start = core_start_q;
    assign irq_done   = irq_q;
    assign core_key   = frame_q[FRAME_W-1 -: KEY_W];
    assign core_din   = frame_q[BLK_W-1:0];

    // FSM state register
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; an abort overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_wr_s && (in_cnt_q == IN_LAST)) state_d = ST_START;
                else                                     state_d = ST_IDLE;
            end
            ST_START: state_d = ST_WAIT_CORE;
            ST_WAIT_CORE: begin
                if (core_done)             state_d = ST_DONE_FLAG;
                else if (wd_q == WD_LAST)  state_d = ST_IDLE;
                else                       state_d = ST_WAIT_CORE;
            end
            ST_DONE_FLAG: begin
                if (ack) state_d = ST_DRAIN;
                else     state_d = ST_DONE_FLAG;
            end
            ST_DRAIN: begin
                if (pop_s && (out_cnt_q == OUT_LAST)) state_d = ST_IDLE;
                else                                   state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_s) state_d = ST_IDLE;
        else         state_d = state_d;
    end

    // FSM outputs, registered so they line up with the state they describe
    always_comb begin
        core_start_d = (state_d == ST_START);
        irq_d        = (state_d == ST_DONE_FLAG) || (state_d == ST_DRAIN);
    end

    // Frame collection, watchdog, result buffer and sticky flags
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        wd_d      = wd_q;
        frame_d   = frame_q;
        obuf_d    = obuf_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        if (abort_s) begin
            in_cnt_d  = 4'd0;
            out_cnt_d = 4'd0;
            wd_d      = '0;
            ovf_d     = 1'b0;
            tmo_d     = 1'b0;
        end else begin
            if (fifo_wr_s && (state_q != ST_IDLE)) ovf_d = 1'b1;
            else                                   ovf_d = ovf_q;
            case (state_q)
                ST_IDLE: begin
                    // shifting in from the LSB end leaves word 0 in the MSBs once full
                    if (fifo_wr_s) begin
                        frame_d  = {frame_q[FRAME_W-DATA_W-1:0], wdata};
                        in_cnt_d = in_cnt_q + 4'd1;
                    end else begin
                        frame_d  = frame_q;
                    end
                end
                ST_START: begin
                    in_cnt_d = 4'd0;
                    wd_d     = '0;
                end
                ST_WAIT_CORE: begin
                    if (core_done) begin
                        obuf_d = core_dout;
                    end else begin
                        wd_d = wd_q + WD_ONE;
                        if (wd_q == WD_LAST) tmo_d = 1'b1;
                        else                 tmo_d = tmo_q;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s) begin
                        obuf_d = obuf_q << DATA_W;
                        if (out_cnt_q == OUT_LAST) out_cnt_d = 4'd0;
                        else                       out_cnt_d = out_cnt_q + 4'd1;
                    end else begin
                        obuf_d = obuf_q;
                    end
                end
                default: begin
                    wd_d = wd_q;
                end
            endcase
        end
    end

    always_comb begin
        status_s        = 32'h0000_0000;
        status_s[0]     = irq_q;
        status_s[1]     = ovf_q;
        status_s[2]     = tmo_q;
        status_s[6:4]   = state_q;
        status_s[11:8]  = in_cnt_q;
        status_s[15:12] = out_cnt_q;
    end

    // Read channel: one response in flight, held until accepted
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rd_fire_s) begin
            rvalid_d = 1'b1;
            if (araddr_q == FIFO_ADDR) begin
                if (state_q == ST_DRAIN) begin
                    rdata_d = obuf_q[BLK_W-1 -: DATA_W];
                    rresp_d = RESP_OK;
                end else begin
                    rdata_d = DEAD_WORD;
                    rresp_d = RESP_ERR;
                end
            end else if (araddr_q == STATUS_ADDR) begin
                rdata_d = DATA_W'(status_s);
                rresp_d = RESP_OK;
            end else begin
                rdata_d = FILL_WORD;
                rresp_d = RESP_OK;
            end
        end else if (rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            in_cnt_q     <= 4'd0;
            out_cnt_q    <= 4'd0;
            wd_q         <= '0;
            frame_q      <= '0;
            obuf_q       <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
        end else begin
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            wd_q         <= wd_d;
            frame_q      <= frame_d;
            obuf_q       <= obuf_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            core_start_q <= core_start_d;
            irq_q        <= irq_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

endmodule

// File: tb/tb_aes_block_stager.sv
// Bench for aes_block_stager: directed table, reset corners and random traffic
// checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_aes_block_stager;

    localparam int N_IN    = 8;
    localparam int N_OUT   = 4;
    localparam int TIMEOUT = 1024;
    localparam logic [31:0] FIFO  = 32'h0000_0510;
    localparam logic [31:0] STAT  = 32'h0000_0514;
    localparam logic [31:0] OTHER = 32'h0000_0600;
    localparam int OP_WR = 0, OP_RD = 1, OP_DONE = 2, OP_ACK = 3, OP_IDLE = 4, OP_FRAME = 5, OP_CORE = 6;

    logic         clk_main_a0 = 1'b0;
    logic         rst_main_n_sync = 1'b0;
    logic [31:0]  wr_addr = 32'h0;
    logic         wready = 1'b0;
    logic [31:0]  wdata = 32'h0;
    logic         arvalid_q = 1'b0;
    logic [31:0]  araddr_q = 32'h0;
    logic         rready = 1'b0;
    logic         rvalid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = 128'h0;
    logic         irq_done;
    logic         ack = 1'b0;

    aes_block_stager #(
        .DATA_W(32), .KEY_W(128), .BLK_W(128),
        .FIFO_ADDR(32'h0000_0510), .STATUS_ADDR(32'h0000_0514), .TIMEOUT_CYC(1024)
    ) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n_sync(rst_main_n_sync),
        .wr_addr(wr_addr), .wready(wready), .wdata(wdata),
        .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
        .core_start(core_start), .core_key(core_key), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout),
        .irq_done(irq_done), .ack(ack)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    always @(negedge clk_main_a0) if (core_start === 1'b1) start_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: the phase code, the words collected so far and the result words still owed
    int           m_st;
    logic [31:0]  m_words[$];
    logic [31:0]  m_res[$];
    bit           m_ovf, m_tmo, m_rv;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    int           m_wd;
    logic [127:0] m_key, m_din;

    task automatic model_reset();
        m_st = 0; m_words.delete(); m_res.delete();
        m_ovf = 1'b0; m_tmo = 1'b0; m_rv = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_wd = 0;
        m_key = 128'h0; m_din = 128'h0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int oc;
        oc = (m_res.size() == 0) ? 0 : N_OUT - m_res.size();
        s = 32'h0;
        s[0] = (m_st == 3 || m_st == 4);
        s[1] = m_ovf;
        s[2] = m_tmo;
        s[6:4] = 3'(m_st);
        s[11:8] = 4'(m_words.size());
        s[15:12] = 4'(oc);
        return s;
    endfunction

    task automatic model_eval();
        bit abort_v, fifo_v, rd_v, pop_v;
        logic [255:0] f;
        abort_v = wready && wr_addr == STAT && wdata[0];
        fifo_v  = wready && wr_addr == FIFO;
        rd_v    = arvalid_q && !m_rv;
        pop_v   = 1'b0;
        if (rd_v) begin
            m_rv = 1'b1;
            if (araddr_q == FIFO) begin
                if (m_st == 4) begin m_rdata = m_res[0]; m_rresp = 2'b00; pop_v = 1'b1; end
                else begin m_rdata = 32'hdead_0000; m_rresp = 2'b10; end
            end else if (araddr_q == STAT) begin
                m_rdata = m_status(); m_rresp = 2'b00;
            end else begin
                m_rdata = 32'haaaa_aaaa; m_rresp = 2'b00;
            end
        end else if (m_rv && rready) begin
            m_rv = 1'b0;
        end
        if (abort_v) begin
            m_st = 0; m_words.delete(); m_res.delete(); m_ovf = 1'b0; m_tmo = 1'b0; m_wd = 0;
        end else begin
            if (fifo_v && m_st != 0) m_ovf = 1'b1;
            case (m_st)
                0: if (fifo_v) begin
                    m_words.push_back(wdata);
                    if (m_words.size() == N_IN) begin
                        f = 256'h0;
                        foreach (m_words[i]) f = {f[223:0], m_words[i]};
                        m_key = f[255:128]; m_din = f[127:0]; m_st = 1;
                    end
                end
                1: begin m_words.delete(); m_wd = 0; m_st = 2; end
                2: if (core_done) begin
                    for (int i = 0; i < N_OUT; i++) m_res.push_back(core_dout[127-32*i -: 32]);
                    m_st = 3;
                end else begin
                    m_wd++;
                    if (m_wd == TIMEOUT) begin m_tmo = 1'b1; m_st = 0; end
                end
                3: if (ack) m_st = 4;
                4: if (pop_v) begin
                    void'(m_res.pop_front());
                    if (m_res.size() == 0) m_st = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk_main_a0); #1;
        chk("rvalid", 128'(rvalid), 128'(m_rv));
        chk("rdata", 128'(rdata), 128'(m_rdata));
        chk("rresp", 128'(rresp), 128'(m_rresp));
        chk("core_start", 128'(core_start), 128'(m_st == 1));
        chk("irq_done", 128'(irq_done), 128'(m_st == 3 || m_st == 4));
        if (m_st >= 1 && m_st <= 4) begin
            chk("core_key", core_key, m_key);
            chk("core_din", core_din, m_din);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        wready = 1'b1; wr_addr = addr; wdata = data;
        step();
        wready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input logic [1:0] eresp,
                           input int hold, input string name);
        int n = 0;
        arvalid_q = 1'b1; araddr_q = addr; rready = 1'b0;
        step();
        arvalid_q = 1'b0;
        while (rvalid !== 1'b1 && n < 16) begin step(); n++; end
        chk({name, "_rvalid"}, 128'(rvalid), 128'(1'b1));
        chk({name, "_rdata"}, 128'(rdata), 128'(exp));
        chk({name, "_rresp"}, 128'(rresp), 128'(eresp));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, "_hold_rvalid"}, 128'(rvalid), 128'(1'b1));
            chk({name, "_hold_rdata"}, 128'(rdata), 128'(exp));
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    typedef struct {
        int           op;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [1:0]   resp;
        int           n;
        logic [127:0] w1;
        logic [127:0] w2;
        string        name;
    } vec_t;

    function automatic vec_t mk(input int op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] resp, input int n, input logic [127:0] w1,
                                input logic [127:0] w2, input string name);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.resp = resp; v.n = n; v.w1 = w1; v.w2 = w2; v.name = name;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [127:0] res_a, res_b;
        int sel;
        res_a = 128'h11111111_22222222_33333333_44444444;
        res_b = 128'hcafef00d_01234567_89abcdef_5a5a5a5a;

        tbl.push_back(mk(OP_RD,    FIFO,  32'hdead_0000, 2'b10, 0, 128'h0, 128'h0, "fifo_idle"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0000, 2'b00, 0, 128'h0, 128'h0, "status_reset"));
        tbl.push_back(mk(OP_RD,    OTHER, 32'haaaa_aaaa, 2'b00, 0, 128'h0, 128'h0, "other_addr"));
        tbl.push_back(mk(OP_FRAME, FIFO,  32'h0000_0000, 2'b00, 0, 128'h0, 128'h0, "frame0"));
        tbl.push_back(mk(OP_IDLE,  0,     32'h0,         2'b00, 2, 128'h0, 128'h0, "idle"));
        tbl.push_back(mk(OP_CORE,  0,     32'h0,         2'b00, 1,
                         128'h00000000_00000001_00000002_00000003,
                         128'h00000004_00000005_00000006_00000007, "core0"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0020, 2'b00, 0, 128'h0, 128'h0, "status_wait"));
        tbl.push_back(mk(OP_WR,    FIFO,  32'h0000_0009, 2'b00, 0, 128'h0, 128'h0, "ovf_write"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0022, 2'b00, 0, 128'h0, 128'h0, "status_ovf"));
        tbl.push_back(mk(OP_DONE,  0,     32'h0,         2'b00, 0, res_a,  128'h0, "done_a"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0033, 2'b00, 0, 128'h0, 128'h0, "status_doneflag"));
        tbl.push_back(mk(OP_RD,    FIFO,  32'hdead_0000, 2'b10, 0, 128'h0, 128'h0, "fifo_doneflag"));
        tbl.push_back(mk(OP_ACK,   0,     32'h0,         2'b00, 0, 128'h0, 128'h0, "ack"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0043, 2'b00, 5, 128'h0, 128'h0, "status_drain_held"));
        tbl.push_back(mk(OP_RD,    FIFO,  32'h1111_1111, 2'b00, 0, 128'h0, 128'h0, "pop0"));
        tbl.push_back(mk(OP_RD,    FIFO,  32'h2222_2222, 2'b00, 0, 128'h0, 128'h0, "pop1"));
        tbl.push_back(mk(OP_RD,    FIFO,  32'h3333_3333, 2'b00, 0, 128'h0, 128'h0, "pop2"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_3043, 2'b00, 0, 128'h0, 128'h0, "status_outcnt3"));
        tbl.push_back(mk(OP_RD,    FIFO,  32'h4444_4444, 2'b00, 0, 128'h0, 128'h0, "pop3"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0002, 2'b00, 0, 128'h0, 128'h0, "status_drained"));
        tbl.push_back(mk(OP_WR,    STAT,  32'h0000_0001, 2'b00, 0, 128'h0, 128'h0, "abort0"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0000, 2'b00, 0, 128'h0, 128'h0, "status_abort0"));
        tbl.push_back(mk(OP_FRAME, FIFO,  32'h0000_0010, 2'b00, 0, 128'h0, 128'h0, "frame1"));
        tbl.push_back(mk(OP_IDLE,  0,     32'h0,         2'b00, 2, 128'h0, 128'h0, "idle"));
        tbl.push_back(mk(OP_CORE,  0,     32'h0,         2'b00, 2,
                         128'h00000010_00000011_00000012_00000013,
                         128'h00000014_00000015_00000016_00000017, "core1"));
        tbl.push_back(mk(OP_DONE,  0,     32'h0,         2'b00, 0, res_b,  128'h0, "done_b"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0031, 2'b00, 0, 128'h0, 128'h0, "status_doneflag2"));
        tbl.push_back(mk(OP_WR,    STAT,  32'h0000_0001, 2'b00, 0, 128'h0, 128'h0, "abort_doneflag"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0000, 2'b00, 0, 128'h0, 128'h0, "status_abort1"));
        tbl.push_back(mk(OP_WR,    FIFO,  32'h0000_0005, 2'b00, 0, 128'h0, 128'h0, "partial0"));
        tbl.push_back(mk(OP_WR,    FIFO,  32'h0000_0006, 2'b00, 0, 128'h0, 128'h0, "partial1"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0200, 2'b00, 0, 128'h0, 128'h0, "status_incnt2"));
        tbl.push_back(mk(OP_WR,    STAT,  32'h0000_0001, 2'b00, 0, 128'h0, 128'h0, "abort_partial"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0000, 2'b00, 0, 128'h0, 128'h0, "status_abort2"));
        tbl.push_back(mk(OP_FRAME, FIFO,  32'h0000_0020, 2'b00, 0, 128'h0, 128'h0, "frame2"));
        tbl.push_back(mk(OP_IDLE,  0,     32'h0,         2'b00, TIMEOUT, 128'h0, 128'h0, "idle"));
        tbl.push_back(mk(OP_DONE,  0,     32'h0,         2'b00, 0, res_a,  128'h0, "done_terminal"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0031, 2'b00, 0, 128'h0, 128'h0, "status_done_wins"));
        tbl.push_back(mk(OP_WR,    STAT,  32'h0000_0001, 2'b00, 0, 128'h0, 128'h0, "abort3"));
        tbl.push_back(mk(OP_FRAME, FIFO,  32'h0000_0030, 2'b00, 0, 128'h0, 128'h0, "frame3"));
        tbl.push_back(mk(OP_IDLE,  0,     32'h0,         2'b00, TIMEOUT + 1, 128'h0, 128'h0, "idle"));
        tbl.push_back(mk(OP_RD,    STAT,  32'h0000_0004, 2'b00, 0, 128'h0, 128'h0, "status_timeout"));

        // Reset state, sampled while reset is still asserted
        model_reset();
        #3;
        chk("rst_rvalid", 128'(rvalid), 128'h0);
        chk("rst_rdata", 128'(rdata), 128'h0);
        chk("rst_rresp", 128'(rresp), 128'h0);
        chk("rst_core_start", 128'(core_start), 128'h0);
        chk("rst_irq_done", 128'(irq_done), 128'h0);
        repeat (2) @(posedge clk_main_a0);
        #1 rst_main_n_sync = 1'b1;

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR:    do_write(tbl[i].addr, tbl[i].data);
                OP_RD:    do_read(tbl[i].addr, tbl[i].data, tbl[i].resp, tbl[i].n, tbl[i].name);
                OP_DONE:  begin core_done = 1'b1; core_dout = tbl[i].w1; step(); core_done = 1'b0; end
                OP_ACK:   begin ack = 1'b1; step(); ack = 1'b0; end
                OP_IDLE:  repeat (tbl[i].n) step();
                OP_FRAME: for (int k = 0; k < N_IN; k++) do_write(FIFO, tbl[i].data + 32'(k));
                OP_CORE:  begin
                    chk({tbl[i].name, "_key"}, core_key, tbl[i].w1);
                    chk({tbl[i].name, "_din"}, core_din, tbl[i].w2);
                    chk({tbl[i].name, "_starts"}, 128'(start_cnt), 128'(tbl[i].n));
                end
                default: ;
            endcase
        end

        // Reset asserted in WAIT_CORE with a read response pending
        for (int k = 0; k < N_IN; k++) do_write(FIFO, 32'h0000_0040 + 32'(k));
        repeat (3) step();
        arvalid_q = 1'b1; araddr_q = STAT; rready = 1'b0;
        step();
        arvalid_q = 1'b0;
        #2 rst_main_n_sync = 1'b0;
        #1;
        model_reset();
        chk("midrst_rvalid", 128'(rvalid), 128'h0);
        chk("midrst_rdata", 128'(rdata), 128'h0);
        chk("midrst_rresp", 128'(rresp), 128'h0);
        chk("midrst_core_start", 128'(core_start), 128'h0);
        chk("midrst_irq_done", 128'(irq_done), 128'h0);
        chk("midrst_core_key", core_key, 128'h0);
        chk("midrst_core_din", core_din, 128'h0);
        @(posedge clk_main_a0);
        #1 rst_main_n_sync = 1'b1;
        do_read(STAT, 32'h0000_0000, 2'b00, 0, "status_after_rst");

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wready = ($urandom % 4) == 0;
            sel = int'($urandom % 20);
            wr_addr = (sel == 0) ? STAT : (sel < 17) ? FIFO : OTHER;
            wdata = $urandom;
            arvalid_q = ($urandom % 3) == 0;
            sel = int'($urandom % 10);
            araddr_q = (sel < 6) ? FIFO : (sel < 8) ? STAT : OTHER;
            rready = ($urandom % 2) == 0;
            core_done = ($urandom % 6) == 0;
            core_dout = {$urandom, $urandom, $urandom, $urandom};
            ack = ($urandom % 5) == 0;
            step();
        end
        wready = 1'b0; arvalid_q = 1'b0; core_done = 1'b0; ack = 1'b0; rready = 1'b1;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
